// File: rtl/multiplier_pkg.sv
// ============================================================================
//  multiplier_pkg
//  Shared state encoding and constants for the signed shift-add multiplier.
//  Rev 1.0
// ============================================================================
`default_nettype none

package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int         MULT_WIDTH = 8;
  localparam int         MULT_STEPS = 8;
  localparam logic [2:0] LAST_STEP  = 3'd7;

endpackage

`default_nettype wire

// File: rtl/ripple_adder_9.sv
// ============================================================================
//  ripple_adder_9
//  9-bit sign-extended add/subtract of S onto A, gated by M; purely combinational.
//  Rev 1.0
// ============================================================================
`default_nettype none

module ripple_adder_9 (
  input  logic [7:0] A,
  input  logic [7:0] SWADD,
  input  logic       M,
  input  logic       cin,
  output logic [7:0] SA,
  output logic       SX
);

  logic [8:0] w_a;
  logic [8:0] w_b;
  logic [8:0] w_s;
  logic [8:0] w_c;

  // With M low the operand and carry-in are both forced to zero, so A passes through.
  assign w_a = {A[7], A};
  assign w_b = {9{M}} & ({SWADD[7], SWADD} ^ {9{cin}});

  always_comb begin
    w_s    = '0;
    w_c    = '0;
    w_c[0] = M & cin;
    for (int i = 0; i < 9; i++) begin
      w_s[i] = w_a[i] ^ w_b[i] ^ w_c[i];
      if (i < 8) begin
        w_c[i+1] = (w_a[i] & w_b[i]) | (w_c[i] & (w_a[i] ^ w_b[i]));
      end
    end
  end

  assign SA = w_s[7:0];
  assign SX = w_s[8];

endmodule

`default_nettype wire

// File: rtl/multiplier_sequencer.sv
// ============================================================================
//  multiplier_sequencer
//  Register/control unit for the 8-bit signed shift-add multiplier.
//  Optional macro MULT_SKIP_ZERO_EN skips ADD steps whose multiplier bit is 0.
//  Rev 1.0
// ============================================================================
`default_nettype none

module multiplier_sequencer
  import multiplier_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Done
);

  generate
    if (WIDTH != MULT_WIDTH || MULT_STEPS != 8) begin : g_width_check
      $error("multiplier_sequencer supports only an 8-bit, 8-step datapath");
    end
  endgenerate

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic             x_q;
  logic [2:0]       count_q;

  logic             w_last;
  logic             w_m;
  logic [WIDTH-1:0] w_sa;
  logic             w_sx;

  assign w_last = (count_q == LAST_STEP);
  assign w_m    = (state_q == ADD) & b_q[0];

  // The eighth partial product carries negative weight, hence subtract on the last step.
  ripple_adder_9 u_adder (
    .A     (a_q),
    .SWADD (s_q),
    .M     (w_m),
    .cin   (w_last),
    .SA    (w_sa),
    .SX    (w_sx)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      x_q     <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Run) begin
            s_q     <= SW;
            a_q     <= '0;
            x_q     <= 1'b0;
            count_q <= '0;
`ifdef MULT_SKIP_ZERO_EN
            state_q <= b_q[0] ? ADD : SHIFT;
`else
            state_q <= ADD;
`endif
          end else if (ClearA_LoadB) begin
            b_q <= SW;
            a_q <= '0;
            x_q <= 1'b0;
          end
        end
        ADD: begin
          x_q     <= w_sx;
          a_q     <= w_sa;
          state_q <= SHIFT;
        end
        SHIFT: begin
          a_q     <= {x_q, a_q[WIDTH-1:1]};
          b_q     <= {a_q[0], b_q[WIDTH-1:1]};
          count_q <= count_q + 3'd1;
          if (w_last) begin
            state_q <= HOLD;
          end else begin
`ifdef MULT_SKIP_ZERO_EN
            // b_q[1] becomes the multiplier bit once this shift lands.
            state_q <= b_q[1] ? ADD : SHIFT;
`else
            state_q <= ADD;
`endif
          end
        end
        HOLD: begin
          if (!Run) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign X    = x_q;
  assign Done = (state_q == HOLD);

endmodule

`default_nettype wire

// File: tb/tb_multiplier_sequencer.sv
// ============================================================================
//  tb_multiplier_sequencer
//  Directed self-checking bench with a scoreboard of expected products.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_multiplier_sequencer;

  logic       clk;
  logic       Reset;
  logic       Run;
  logic       ClearA_LoadB;
  logic [7:0] SW;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic       X;
  logic       Done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] prod;
    int          lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] b_model;

  multiplier_sequencer #(.WIDTH(8)) dut (
    .Clk          (clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .SW           (SW),
    .Aval         (Aval),
    .Bval         (Bval),
    .X            (X),
    .Done         (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_b(input logic [7:0] v);
    @(negedge clk);
    SW           = v;
    ClearA_LoadB = 1'b1;
    @(negedge clk);
    ClearA_LoadB = 1'b0;
    b_model      = v;
    chk("load_B", {24'd0, Bval}, {24'd0, v});
    chk("load_A", {24'd0, Aval}, 32'd0);
  endtask

  // mode 0: plain start; 1: ClearA_LoadB and SW toggled during the run;
  // 2: ClearA_LoadB raised together with Run at the start edge.
  task automatic run_mult(input logic [7:0] s, input int mode, input string tag);
    exp_t e;
    exp_t got;
    int   p;
    int   cyc;
    p      = int'($signed(b_model)) * int'($signed(s));
    e.prod = p[15:0];
`ifdef MULT_SKIP_ZERO_EN
    e.lat  = 8 + $countones(b_model);
`else
    e.lat  = 16;
`endif
    sb.push_back(e);
    @(negedge clk);
    SW  = s;
    Run = 1'b1;
    if (mode == 2) begin
      ClearA_LoadB = 1'b1;
      SW           = s;
    end
    @(posedge clk);
    cyc = 0;
    @(negedge clk);
    if (mode == 1) begin
      ClearA_LoadB = 1'b1;
      SW           = 8'hFF;
    end else if (mode == 2) begin
      ClearA_LoadB = 1'b0;
    end
    while (cyc <= 40) begin
      if (cyc > 0) @(posedge clk);
      else         @(posedge clk);
      cyc++;
      #1;
      if (Done) break;
    end
    ClearA_LoadB = 1'b0;
    got = sb.pop_front();
    chk({tag, "_latency"}, cyc, got.lat);
    chk({tag, "_product"}, {16'd0, Aval, Bval}, {16'd0, got.prod});
    chk({tag, "_X"}, {31'd0, X}, {31'd0, got.prod[15]});
    b_model = got.prod[7:0];
  endtask

  task automatic release_run();
    @(negedge clk);
    Run = 1'b0;
    @(posedge clk);
    #1;
    chk("done_fall", {31'd0, Done}, 32'd0);
  endtask

  initial begin
    logic [15:0] held;
    Reset        = 1'b1;
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    SW           = 8'h00;
    b_model      = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_A",    {24'd0, Aval}, 32'd0);
    chk("reset_B",    {24'd0, Bval}, 32'd0);
    chk("reset_X",    {31'd0, X},    32'd0);
    chk("reset_Done", {31'd0, Done}, 32'd0);
    Reset = 1'b0;

    load_b(8'h03);
    run_mult(8'h07, 0, "3x7");

    // Run stays high after completion: HOLD with a stable product.
    held = {Aval, Bval};
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("hold_Done",    {31'd0, Done}, 32'd1);
    chk("hold_product", {16'd0, Aval, Bval}, {16'd0, held});
    release_run();

    run_mult(8'h02, 0, "chain_x2");
    release_run();

    load_b(8'h03);
    run_mult(8'hF9, 0, "3xm7");
    release_run();

    load_b(8'hFD);
    run_mult(8'h07, 0, "m3x7");
    release_run();

    load_b(8'h80);
    run_mult(8'h80, 0, "80x80");
    release_run();

    load_b(8'h05);
    run_mult(8'h03, 1, "clear_ignored");
    release_run();

    load_b(8'h02);
    run_mult(8'h03, 2, "run_wins");
    release_run();

    // Asynchronous reset at t0+5 discards the partial result.
    load_b(8'h03);
    @(negedge clk);
    SW  = 8'h07;
    Run = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    Reset = 1'b1;
    #1;
    chk("midreset_A",    {24'd0, Aval}, 32'd0);
    chk("midreset_B",    {24'd0, Bval}, 32'd0);
    chk("midreset_X",    {31'd0, X},    32'd0);
    chk("midreset_Done", {31'd0, Done}, 32'd0);
    @(negedge clk);
    Run   = 1'b0;
    Reset = 1'b0;
    b_model = 8'h00;

    load_b(8'h03);
    run_mult(8'h07, 0, "after_reset");
    release_run();

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
